frame_timer: RTL

- Parametrised successor to the single-channel VSync frame counter.
- Synchronises the VGA VS input and detects each frame start. Maintains a frame counter with configurable modulus.
- Drives NUM_CH independent animation channels. Each channel has a runtime-programmable frame-divide period and emits a tick and a step count.
- Sits between the VGA controller and sprite/scroll logic, and paces animation and scrolling.

---
 rtl/frame_timer_pkg.sv | 18 +
 rtl/frame_anim_channel.sv | 78 +++++++
 rtl/frame_timer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/frame_timer_pkg.sv
// frame_timer_pkg
//   Shared types and helpers for the frame timer slice.
//   - vsync_state_t : vertical-sync tracking FSM states
//   - step_lsb()    : LSB position of a channel's slice in the packed ch_step bus
package frame_timer_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC    = 2'd0,
    IN_SYNC      = 2'd1,
    WAIT_RELEASE = 2'd2
  } vsync_state_t;

  // Channel ch occupies [step_lsb(ch, step_w) +: step_w] of the packed step bus.
  function automatic int step_lsb(input int ch, input int step_w);
    return ch * step_w;
  endfunction

endpackage

// File: rtl/frame_anim_channel.sv
// frame_anim_channel
//   One animation channel: programmable frame-divide period, divider,
//   tick pulse and wrapping step counter. All outputs registered.
//   Ports:
//     frame_Clk  in   clock
//     Reset      in   synchronous active-high reset
//     frame_evt  in   frame event (one cycle, aligned with the edge frame_pulse rises on)
//     pause      in   hold divider and step, suppress tick
//     wr_en      in   load wr_period and clear the divider
//     wr_period  in   new period in frames, 0 disables the channel
//     tick       out  one-cycle pulse when the period elapses
//     step       out  step counter, wraps modulo 2**STEP_W
module frame_anim_channel #(
  parameter int PER_W          = 4,
  parameter int STEP_W         = 3,
  parameter int DEFAULT_PERIOD = 4
) (
  input  logic              frame_Clk,
  input  logic              Reset,
  input  logic              frame_evt,
  input  logic              pause,
  input  logic              wr_en,
  input  logic [PER_W-1:0]  wr_period,
  output logic              tick,
  output logic [STEP_W-1:0] step
);

  localparam logic [PER_W-1:0]  PER_DEFAULT = PER_W'(DEFAULT_PERIOD);
  localparam logic [PER_W-1:0]  PER_ONE     = PER_W'(1'b1);
  localparam logic [PER_W-1:0]  PER_ZERO    = {PER_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1'b1);

  logic [PER_W-1:0]  period_r,  period_nxt_s;
  logic [PER_W-1:0]  div_cnt_r, div_cnt_nxt_s;
  logic [STEP_W-1:0] step_r,    step_nxt_s;
  logic              tick_r,    tick_nxt_s;

  // Next-state: a config write beats a coincident frame event, so that frame never ticks.
  always_comb begin
    period_nxt_s  = period_r;
    div_cnt_nxt_s = div_cnt_r;
    step_nxt_s    = step_r;
    tick_nxt_s    = 1'b0;
    if (wr_en) begin
      period_nxt_s  = wr_period;
      div_cnt_nxt_s = PER_ZERO;
    end else if (frame_evt && !pause && (period_r != PER_ZERO)) begin
      if (div_cnt_r == (period_r - PER_ONE)) begin
        div_cnt_nxt_s = PER_ZERO;
        tick_nxt_s    = 1'b1;
        step_nxt_s    = step_r + STEP_ONE;
      end else begin
        div_cnt_nxt_s = div_cnt_r + PER_ONE;
      end
    end else begin
      div_cnt_nxt_s = div_cnt_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      period_r  <= PER_DEFAULT;
      div_cnt_r <= PER_ZERO;
      step_r    <= {STEP_W{1'b0}};
      tick_r    <= 1'b0;
    end else begin
      period_r  <= period_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      step_r    <= step_nxt_s;
      tick_r    <= tick_nxt_s;
    end
  end

  assign tick = tick_r;
  assign step = step_r;

endmodule

// File: rtl/frame_timer.sv
// frame_timer
//   Synchronises VGA VS, detects one frame per sync pulse, keeps a modulo
//   frame counter and drives NUM_CH programmable animation channels.
//   Ports:
//     frame_Clk    in   clock
//     Reset        in   synchronous active-high reset
//     VS           in   vertical sync (asynchronous)
//     pause        in   freeze FrameCount and channels; frame_pulse still fires
//     cfg_we       in   period write strobe
//     cfg_ch       in   channel index of the write (out-of-range index ignored)
//     cfg_period   in   new period in frames, 0 disables the channel
//     frame_pulse  out  one-cycle pulse per detected frame
//     FrameCount   out  frame counter, wraps after FRAME_MOD-1
//     ch_tick      out  per-channel period-elapsed pulse
//     ch_step      out  packed per-channel step counters
module frame_timer
  import frame_timer_pkg::*;
#(
  parameter int CNT_W          = 6,
  parameter int FRAME_MOD      = 64,
  parameter int NUM_CH         = 4,
  parameter int PER_W          = 4,
  parameter int STEP_W         = 3,
  parameter int DEFAULT_PERIOD = 4,
  parameter int VS_ACTIVE_LOW  = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                         frame_Clk,
  input  logic                                         Reset,
  input  logic                                         VS,
  input  logic                                         pause,
  input  logic                                         cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [PER_W-1:0]                             cfg_period,
  output logic                                         frame_pulse,
  output logic [CNT_W-1:0]                             FrameCount,
  output logic [NUM_CH-1:0]                            ch_tick,
  output logic [NUM_CH*STEP_W-1:0]                     ch_step
);

  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic             VS_INV   = (VS_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_MOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [SYNC_STAGES-1:0] vs_sync_r;
  logic [SYNC_STAGES-1:0] sync_fill_r;
  logic                   vs_act_s;
  logic                   sync_ready_s;
  vsync_state_t           state_r, state_nxt_s;
  logic                   frame_evt_s;
  logic                   frame_pulse_r;
  logic [CNT_W-1:0]       frame_count_r;
  logic [NUM_CH-1:0]      wr_en_s;

  // VS synchroniser. sync_fill_r marks when the chain holds only post-reset samples;
  // until then the inactive reset fill must not be mistaken for a released VS.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      vs_sync_r   <= {SYNC_STAGES{VS_INV}};
      sync_fill_r <= {SYNC_STAGES{1'b0}};
    end else begin
      vs_sync_r[0]   <= VS;
      sync_fill_r[0] <= 1'b1;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        vs_sync_r[k]   <= vs_sync_r[k-1];
        sync_fill_r[k] <= sync_fill_r[k-1];
      end
    end
  end

  assign vs_act_s     = vs_sync_r[SYNC_STAGES-1] ^ VS_INV;
  assign sync_ready_s = sync_fill_r[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      state_r <= WAIT_RELEASE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: IN_SYNC lasts one cycle, giving one frame per sync pulse.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_SYNC: begin
        if (vs_act_s) begin
          state_nxt_s = IN_SYNC;
        end else begin
          state_nxt_s = WAIT_SYNC;
        end
      end
      IN_SYNC: begin
        state_nxt_s = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!vs_act_s && sync_ready_s) begin
          state_nxt_s = WAIT_SYNC;
        end else begin
          state_nxt_s = WAIT_RELEASE;
        end
      end
      default: begin
        state_nxt_s = WAIT_RELEASE;
      end
    endcase
  end

  assign frame_evt_s = (state_r == IN_SYNC);

  // Frame pulse and modulo frame counter.
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      frame_pulse_r <= 1'b0;
      frame_count_r <= {CNT_W{1'b0}};
    end else begin
      frame_pulse_r <= frame_evt_s;
      if (frame_evt_s && !pause) begin
        if (frame_count_r == CNT_LAST) begin
          frame_count_r <= {CNT_W{1'b0}};
        end else begin
          frame_count_r <= frame_count_r + CNT_ONE;
        end
      end
    end
  end

  assign frame_pulse = frame_pulse_r;
  assign FrameCount  = frame_count_r;

  // Channel array; an index with no matching channel decodes to no write.
  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

    assign wr_en_s[i] = cfg_we && (cfg_ch == CH_IDX);

    frame_anim_channel #(
      .PER_W          (PER_W),
      .STEP_W         (STEP_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .frame_Clk (frame_Clk),
      .Reset     (Reset),
      .frame_evt (frame_evt_s),
      .pause     (pause),
      .wr_en     (wr_en_s[i]),
      .wr_period (cfg_period),
      .tick      (ch_tick[i]),
      .step      (ch_step[step_lsb(i, STEP_W) +: STEP_W])
    );
  end

endmodule
